display_scan: RTL and testbench

- Time-multiplexing scanner for the 4-digit 7-segment display. It is the driving end of the digit/anode interface that the 7-segment decoder consumes.
- Takes a 16-bit packed BCD value and produces seg_number[3:0] and an_number[1:0], rotating through the four digit positions at a fixed refresh rate.
- Snapshots the input once per frame so a frame never shows digits from two different values. A hold input freezes the snapshot.

---
 rtl/display_scan_if.sv | 28 ++
 rtl/display_scan.sv | 101 ++++++++++
 tb/tb_display_scan.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Digit/anode bus between the 7-segment scanner (master) and its consumer (slave).
// The value and hold inputs travel with the bus so the scanner sees a single port.
interface display_scan_if;
   logic [15:0] digits;
   logic        hold;
   logic [3:0]  seg_number;
   logic [1:0]  an_number;
   logic        scan_tick;
   logic        frame_start;

   modport master (
      input  digits,
      input  hold,
      output seg_number,
      output an_number,
      output scan_tick,
      output frame_start
   );

   modport slave (
      output digits,
      output hold,
      input  seg_number,
      input  an_number,
      input  scan_tick,
      input  frame_start
   );
endinterface

// File: rtl/display_scan.sv
// 4-digit 7-segment scanner: rotates an_number/seg_number every REFRESH_DIV cycles,
// snapshotting the packed BCD value once per frame so a frame is always coherent.
//
// state    | meaning
// ST_PRIME | first edge after reset: load snapshot (unless held), start counter
// ST_SCAN  | normal scanning, advance on refresh terminal count
module display_scan #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   display_scan_if.master bus
);

   typedef enum logic {ST_PRIME, ST_SCAN} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   state_t            state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [1:0]        an_q,     an_d;
   logic [3:0]        seg_q,    seg_d;
   logic [15:0]       snap_q,   snap_d;
   logic              tick_q,   tick_d;
   logic              frame_q,  frame_d;
   logic              advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_PRIME;
         cnt_q   <= '0;
         an_q    <= 2'd0;
         seg_q   <= 4'd0;
         snap_q  <= 16'h0000;
         tick_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         snap_q  <= snap_d;
         tick_q  <= tick_d;
         frame_q <= frame_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      an_d    = an_q;
      seg_d   = seg_q;
      snap_d  = snap_q;
      tick_d  = 1'b0;
      frame_d = 1'b0;
      advance = 1'b0;

      case (state_q)
         ST_PRIME: begin
            state_d = ST_SCAN;
            cnt_d   = cnt_q + CNT_W'(1);
            if (!bus.hold) begin
               snap_d = bus.digits;
               seg_d  = bus.digits[15:12];
            end
         end
         ST_SCAN: begin
            advance = (cnt_q == CNT_LAST);
            cnt_d   = advance ? '0 : cnt_q + CNT_W'(1);
         end
         default: state_d = ST_PRIME;
      endcase

      if (advance) begin
         an_d   = an_q + 2'd1;
         tick_d = 1'b1;
         case (an_q)
            2'd3: begin
               // Frame boundary: fresh value comes straight from the input, not the old snapshot.
               frame_d = 1'b1;
               if (!bus.hold) begin
                  snap_d = bus.digits;
                  seg_d  = bus.digits[15:12];
               end else begin
                  seg_d  = snap_q[15:12];
               end
            end
            2'd0:    seg_d = snap_q[11:8];
            2'd1:    seg_d = snap_q[7:4];
            default: seg_d = snap_q[3:0];
         endcase
      end
   end

   assign bus.seg_number  = seg_q;
   assign bus.an_number   = an_q;
   assign bus.scan_tick   = tick_q;
   assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: two instances (divider 4 and 2) compared
// every cycle against a time-based reference model of the scan/snapshot rules.
module tb_display_scan;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   display_scan_if bus4();
   display_scan_if bus2();

   display_scan #(.REFRESH_DIV(4), .CNT_W(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   display_scan #(.REFRESH_DIV(2), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   // Model: k = rising edges since reset release. Edge 1 primes, every DIV-th edge
   // advances, every 4*DIV-th edge is a frame boundary that may reload the snapshot.
   int          k4, k2;
   logic [15:0] snap4, snap2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k4 = 0; k2 = 0; snap4 = 16'h0; snap2 = 16'h0;
      end else begin
         k4++; k2++;
         if ((k4 == 1 || k4 % 16 == 0) && !bus4.hold) snap4 = bus4.digits;
         if ((k2 == 1 || k2 % 8 == 0) && !bus2.hold) snap2 = bus2.digits;
      end
   end

   function automatic logic [3:0] nib(input logic [15:0] v, input int p);
      return v[4*(3-p) +: 4];
   endfunction

   // {an, seg, tick, frame}
   function automatic logic [7:0] exp_out(input int k, input int div, input logic [15:0] snap);
      int an;
      an = (k / div) % 4;
      return {2'(an), nib(snap, an), 1'(k > 0 && k % div == 0), 1'(k > 0 && k % (4*div) == 0)};
   endfunction

   function automatic logic [7:0] act4();
      return {bus4.an_number, bus4.seg_number, bus4.scan_tick, bus4.frame_start};
   endfunction

   function automatic logic [7:0] act2();
      return {bus2.an_number, bus2.seg_number, bus2.scan_tick, bus2.frame_start};
   endfunction

   task automatic release_reset();
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus4.digits = 16'h1234; bus4.hold = 1'b0;
      bus2.digits = 16'hF0A9; bus2.hold = 1'b0;
      #12;
      checks++;
      if (act4() !== 8'h00) begin errors++; $display("FAIL reset4 got %h exp 00", act4()); end
      checks++;
      if (act2() !== 8'h00) begin errors++; $display("FAIL reset2 got %h exp 00", act2()); end
   endtask

   task automatic test_priming();
      release_reset();
      @(posedge clk); #1;
      checks++;
      if (bus4.seg_number !== 4'h1 || bus4.an_number !== 2'd0) begin
         errors++; $display("FAIL prime_first seg=%h an=%0d exp seg=1 an=0", bus4.seg_number, bus4.an_number);
      end
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         checks++;
         if (act4() !== exp_out(k4, 4, snap4)) begin
            errors++; $display("FAIL priming k=%0d got %h exp %h", k4, act4(), exp_out(k4, 4, snap4));
         end
      end
   endtask

   task automatic test_coherence();
      for (int i = 0; i < 40 && bus4.an_number !== 2'd1; i++) begin @(posedge clk); #1; end
      checks++;
      if (bus4.an_number !== 2'd1) begin errors++; $display("FAIL coh_wait an=%0d exp 1", bus4.an_number); end
      bus4.digits = 16'h5678;
      for (int c = 0; c < 28; c++) begin
         @(posedge clk); #1;
         checks++;
         if (act4() !== exp_out(k4, 4, snap4)) begin
            errors++; $display("FAIL coherence k=%0d got %h exp %h", k4, act4(), exp_out(k4, 4, snap4));
         end
         if (bus4.frame_start === 1'b1) begin
            checks++;
            if (bus4.seg_number !== 4'h5) begin errors++; $display("FAIL coh_frame seg=%h exp 5", bus4.seg_number); end
         end
      end
   endtask

   task automatic test_hold();
      bus4.digits = 16'h1234;
      for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
      bus4.hold = 1'b1;
      bus4.digits = 16'h9999;
      for (int c = 0; c < 48; c++) begin
         @(posedge clk); #1;
         checks++;
         if (act4() !== exp_out(k4, 4, snap4) || bus4.seg_number === 4'h9) begin
            errors++; $display("FAIL hold k=%0d got %h exp %h", k4, act4(), exp_out(k4, 4, snap4));
         end
      end
      bus4.hold = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         checks++;
         if (act4() !== exp_out(k4, 4, snap4)) begin
            errors++; $display("FAIL unhold k=%0d got %h exp %h", k4, act4(), exp_out(k4, 4, snap4));
         end
      end
   endtask

   task automatic test_hold_priming();
      rst_n = 1'b0;
      bus4.digits = 16'h4321; bus4.hold = 1'b1;
      release_reset();
      for (int c = 0; c < 40; c++) begin
         if (c == 20) bus4.hold = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (act4() !== exp_out(k4, 4, snap4)) begin
            errors++; $display("FAIL hold_prime k=%0d got %h exp %h", k4, act4(), exp_out(k4, 4, snap4));
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 40 && bus4.an_number !== 2'd2; i++) begin @(posedge clk); #1; end
      checks++;
      if (bus4.an_number !== 2'd2) begin errors++; $display("FAIL rst_wait an=%0d exp 2", bus4.an_number); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (act4() !== 8'h00) begin errors++; $display("FAIL reset_mid got %h exp 00", act4()); end
      release_reset();
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         checks++;
         if (act4() !== exp_out(k4, 4, snap4)) begin
            errors++; $display("FAIL after_rst k=%0d got %h exp %h", k4, act4(), exp_out(k4, 4, snap4));
         end
      end
   endtask

   task automatic test_boundary_div2();
      rst_n = 1'b0;
      bus2.digits = 16'hF0A9; bus2.hold = 1'b0;
      release_reset();
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         checks++;
         if (act2() !== exp_out(k2, 2, snap2)) begin
            errors++; $display("FAIL div2 k=%0d got %h exp %h", k2, act2(), exp_out(k2, 2, snap2));
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus4.digits = 16'($urandom);
         bus2.digits = 16'($urandom);
         if ($urandom_range(0, 9) == 0) bus4.hold = ~bus4.hold;
         if ($urandom_range(0, 9) == 0) bus2.hold = ~bus2.hold;
         @(posedge clk); #1;
         checks++;
         if (act4() !== exp_out(k4, 4, snap4)) begin
            errors++; $display("FAIL rand4 k=%0d got %h exp %h", k4, act4(), exp_out(k4, 4, snap4));
         end
         checks++;
         if (act2() !== exp_out(k2, 2, snap2)) begin
            errors++; $display("FAIL rand2 k=%0d got %h exp %h", k2, act2(), exp_out(k2, 2, snap2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_priming();
      test_coherence();
      test_hold();
      test_hold_priming();
      test_reset_mid();
      test_boundary_div2();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
